vme_system_controller: RTL and testbench
========================================

Name: vme_system_controller

Overview:
- VME slot-1 system-controller functions for the computie-vme k30p card. Sits downstream of the card's bus-request logic: consumes the VME BR0-BR3 lines, including this card's own request, and BBSY.
- Drives the BG daisy-chain heads, which feed this card's bus-grant input and the backplane. Drives BCLR.
- Contains the global data-transfer bus timer, which asserts BERR on unanswered cycles.
- All backplane signals are active-low; the enclosing top level turns the `*_out` signals into open-drain/tristate pins.

Parameters:
- ARB_MODE, 0, 0 = fixed priority (PRI: BR3 highest), 1 = round robin (RRS).
- BUS_TIMEOUT, 3200, clock cycles of unanswered DS before BERR is asserted (64 us at 50 MHz); 1..4095.
- GRANT_TIMEOUT, 255, clock cycles to wait for BBSY after a BG is driven; 1..255.

Ports:
- clock  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- vme_br  input  4  bus requests BR[3:0], active-low, asynchronous.
- vme_bbsy  input  1  bus busy, active-low, asynchronous.
- vme_as  input  1  VME address strobe, active-low.
- vme_ds  input  2  VME data strobes, active-low.
- vme_dtack  input  1  VME DTACK, active-low.
- vme_berr_in  input  1  backplane BERR as sampled from the bus, active-low.
- vme_bg_out  output  4  BG[3:0]IN to the slot-1 daisy chain, active-low.
- vme_bclr  output  1  bus clear, active-low.
- vme_berr_out  output  1  bus-timer BERR drive, active-low.
- grant_level  output  2  level currently granted or last granted.
- arb_busy  output  1  high while in the GRANT or BUSY state.
- timeout_event  output  1  one-clock pulse when the bus timer fires or a grant times out.

Behaviour:
- Reset is asynchronous and active-high; it applies immediately, including mid-operation. Reset values:
  - vme_bg_out = 4'b1111, vme_bclr = 1, vme_berr_out = 1.
  - grant_level = 2'b11, arb_busy = 0, timeout_event = 0.
  - State = IDLE, round-robin pointer = 3, all counters = 0.
- Synchronisation: every backplane input passes through a 2-flop synchroniser. All decisions below use the synchronised values ("s_" prefix).
- Arbiter states: IDLE, GRANT, BUSY, RELEASE.
- IDLE:
  - Condition: any s_br low and s_bbsy high.
  - Level choice, ARB_MODE=0: highest requesting level.
  - Level choice, ARB_MODE=1: first requesting level searching downward from pointer-1, wrapping 0 to 3.
  - Action: register grant_level, drive vme_bg_out[level] low, go to GRANT.
  - Latency: BG goes low on the 3rd rising clock after BR meets setup at the input pins.
  - If s_bbsy is low in IDLE (another arbiter's master or a stale owner), go to BUSY without driving BG.
- GRANT:
  - Exactly one BG bit is low; no other BG bit is ever low at the same time.
  - s_bbsy low: negate BG next clock, go to BUSY, set pointer = grant_level.
  - GRANT_TIMEOUT cycles elapse without s_bbsy: negate BG, pulse timeout_event, go to IDLE.
  - The requester withdrawing BR does not shorten the wait.
- BUSY:
  - ARB_MODE=0: vme_bclr is low while any s_br level is higher than grant_level.
  - ARB_MODE=1: vme_bclr stays high.
  - s_bbsy high: negate BCLR, go to RELEASE.
- RELEASE: one mandatory dead cycle with all BG high, then IDLE. A new grant is therefore never issued in the same clock that BBSY releases.
- arb_busy = 1 in GRANT and BUSY.
- Bus timer (independent of the arbiter):
  - Counter is 12 bits and saturates at BUS_TIMEOUT.
  - Increments each clock while s_as low, any s_ds bit low, s_dtack high and s_berr_in high.
  - Clears when both s_ds are high, or when s_dtack or s_berr_in goes low.
  - On reaching BUS_TIMEOUT: vme_berr_out low from the next clock and timeout_event pulses once.
  - vme_berr_out stays low until both s_ds are high, then returns high within 1 clock and the counter clears.
  - A DTACK arriving on the same cycle the count reaches BUS_TIMEOUT wins: no BERR is asserted.
- timeout_event events from the bus timer and the arbiter in the same clock merge into a single pulse.

Test Plan:
- Reset, then BR2 low with BBSY high -> vme_bg_out = 4'b1011 on the 3rd clock; BBSY low -> BG 4'b1111 and arb_busy = 1; BBSY high -> RELEASE, then IDLE.
- ARB_MODE=0, BR0 owner holds BBSY while BR3 asserts -> vme_bclr low within 3 clocks; BBSY released -> one dead cycle, then vme_bg_out = 4'b0111.
- ARB_MODE=1, BR0-BR3 all held, each owner releases after 10 cycles -> grant order 3, 2, 1, 0, 3; vme_bclr never low.
- BG driven and BBSY never asserted -> after GRANT_TIMEOUT=255 cycles BG returns to 4'b1111, timeout_event pulses once, and arbitration resumes.
- AS and DS[0] held low with no DTACK, BUS_TIMEOUT=3200 -> vme_berr_out low at count 3200 (+sync latency); DS released -> BERR high within 1 clock. Repeat with DTACK at cycle 3199 -> no BERR.
- Assert reset while in BUSY with BERR active -> all outputs return to reset values immediately (asynchronously); after reset drops, BR1 is granted normally.

Source files
------------

// File: rtl/vme_system_controller.sv
// VME slot-1 system controller for the k30p card.
//   - Bus arbiter: watches BR[3:0] and BBSY, drives the BG[3:0] daisy-chain
//     heads and BCLR. Fixed priority (BR3 highest) or round robin.
//   - Global data-transfer bus timer: drives BERR when a strobed cycle is
//     never answered by DTACK or BERR.
// Ports:
//   clock, reset          system clock, async active-high reset
//   vme_br[3:0]           bus requests (active-low, async)
//   vme_bbsy              bus busy (active-low, async)
//   vme_as, vme_ds[1:0]   address / data strobes (active-low)
//   vme_dtack             DTACK (active-low)
//   vme_berr_in           backplane BERR as seen on the bus (active-low)
//   vme_bg_out[3:0]       BG[3:0]IN daisy-chain heads (active-low)
//   vme_bclr              bus clear (active-low)
//   vme_berr_out          bus-timer BERR drive (active-low)
//   grant_level           level currently / last granted
//   arb_busy              high in GRANT or BUSY
//   timeout_event         1-clock pulse on bus-timer or grant timeout
module vme_system_controller #(
    parameter int ARB_MODE      = 0,
    parameter int BUS_TIMEOUT   = 3200,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] vme_br,
    input  logic       vme_bbsy,
    input  logic       vme_as,
    input  logic [1:0] vme_ds,
    input  logic       vme_dtack,
    input  logic       vme_berr_in,
    output logic [3:0] vme_bg_out,
    output logic       vme_bclr,
    output logic       vme_berr_out,
    output logic [1:0] grant_level,
    output logic       arb_busy,
    output logic       timeout_event
);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

    localparam logic [11:0] BUS_LIMIT  = 12'(BUS_TIMEOUT);
    localparam logic [7:0]  GRANT_LAST = 8'(GRANT_TIMEOUT - 1);

    // Two-flop synchroniser for every backplane input. Idle level of all
    // these active-low lines is high, so the chain resets to ones.
    logic [9:0] sync_meta, sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= '1;
            sync_q    <= '1;
        end else begin
            sync_meta <= {vme_br, vme_bbsy, vme_as, vme_ds, vme_dtack, vme_berr_in};
            sync_q    <= sync_meta;
        end
    end

    logic [3:0] s_br;
    logic       s_bbsy, s_as, s_dtack, s_berr_in;
    logic [1:0] s_ds;

    assign {s_br, s_bbsy, s_as, s_ds, s_dtack, s_berr_in} = sync_q;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    state_t     state, state_n;
    logic [3:0] bg_n;
    logic [1:0] ptr, ptr_n, level_n, pick_level;
    logic [7:0] gcnt, gcnt_n;
    logic       bclr_n, arb_timeout, pick_valid, higher_req;

    assign pick_valid = (s_br != 4'hF);

    // Level selection. Loops run lowest-priority first so the last match
    // is the winner.
    always_comb begin
        pick_level = 2'd0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < 4; i++)
                if (!s_br[i]) pick_level = 2'(i);
        end else begin
            // search order ptr-1, ptr-2, ptr-3, ptr (2-bit wrap)
            for (int k = 4; k >= 1; k--)
                if (!s_br[ptr - 2'(k)]) pick_level = ptr - 2'(k);
        end
    end

    always_comb begin
        higher_req = 1'b0;
        for (int i = 0; i < 4; i++)
            if (!s_br[i] && i > int'(grant_level)) higher_req = 1'b1;
    end

    always_comb begin
        state_n     = state;
        bg_n        = 4'hF;
        level_n     = grant_level;
        ptr_n       = ptr;
        gcnt_n      = gcnt;
        bclr_n      = 1'b1;
        arb_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!s_bbsy) begin
                    // someone already owns the bus: track it, grant nothing
                    state_n = BUSY;
                end else if (pick_valid) begin
                    level_n = pick_level;
                    bg_n    = ~(4'b0001 << pick_level);
                    gcnt_n  = 8'd0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                bg_n = vme_bg_out;
                if (!s_bbsy) begin
                    bg_n    = 4'hF;
                    ptr_n   = grant_level;
                    state_n = BUSY;
                end else if (gcnt == GRANT_LAST) begin
                    bg_n        = 4'hF;
                    arb_timeout = 1'b1;
                    state_n     = IDLE;
                end else begin
                    gcnt_n = gcnt + 8'd1;
                end
            end
            BUSY: begin
                if (s_bbsy)
                    state_n = RELEASE;
                else if (ARB_MODE == 0 && higher_req)
                    bclr_n = 1'b0;
            end
            RELEASE: state_n = IDLE;   // dead cycle before the next grant
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            vme_bg_out  <= 4'hF;
            vme_bclr    <= 1'b1;
            grant_level <= 2'b11;
            ptr         <= 2'b11;
            gcnt        <= 8'd0;
        end else begin
            state       <= state_n;
            vme_bg_out  <= bg_n;
            vme_bclr    <= bclr_n;
            grant_level <= level_n;
            ptr         <= ptr_n;
            gcnt        <= gcnt_n;
        end
    end

    assign arb_busy = (state == GRANT) || (state == BUSY);

    // ------------------------------------------------------------------
    // Bus timer
    // ------------------------------------------------------------------
    logic [11:0] bcnt;
    logic        bt_clear, bt_active, bt_fire;

    // DTACK/BERR taking priority over the saturated count means a late
    // DTACK still wins against the timer.
    assign bt_clear  = (&s_ds) || !s_dtack || !s_berr_in;
    assign bt_active = !s_as && !bt_clear;
    assign bt_fire   = !bt_clear && (bcnt == BUS_LIMIT) && vme_berr_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcnt          <= 12'd0;
            vme_berr_out  <= 1'b1;
            timeout_event <= 1'b0;
        end else begin
            if (bt_clear)
                bcnt <= 12'd0;
            else if (bt_active && bcnt != BUS_LIMIT)
                bcnt <= bcnt + 12'd1;

            // BERR is held until the master drops its data strobes
            if (&s_ds)
                vme_berr_out <= 1'b1;
            else if (bt_fire)
                vme_berr_out <= 1'b0;

            timeout_event <= arb_timeout | bt_fire;
        end
    end

endmodule

// File: tb/tb_vme_system_controller.sv
module tb_vme_system_controller;

    localparam int BT = 3200;
    localparam int GT = 255;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] br;
    logic       bbsy, astb, dtack, berr_in;
    logic [1:0] ds;

    logic [3:0] bg   [2];
    logic       bclr [2];
    logic       berr [2];
    logic [1:0] lvl  [2];
    logic       busy [2];
    logic       tev  [2];

    // instance 0: fixed priority, instance 1: round robin; shared inputs
    vme_system_controller #(.ARB_MODE(0), .BUS_TIMEOUT(BT), .GRANT_TIMEOUT(GT)) u_fp (
        .clock(clock), .reset(reset), .vme_br(br), .vme_bbsy(bbsy), .vme_as(astb),
        .vme_ds(ds), .vme_dtack(dtack), .vme_berr_in(berr_in),
        .vme_bg_out(bg[0]), .vme_bclr(bclr[0]), .vme_berr_out(berr[0]),
        .grant_level(lvl[0]), .arb_busy(busy[0]), .timeout_event(tev[0]));

    vme_system_controller #(.ARB_MODE(1), .BUS_TIMEOUT(BT), .GRANT_TIMEOUT(GT)) u_rr (
        .clock(clock), .reset(reset), .vme_br(br), .vme_bbsy(bbsy), .vme_as(astb),
        .vme_ds(ds), .vme_dtack(dtack), .vme_berr_in(berr_in),
        .vme_bg_out(bg[1]), .vme_bclr(bclr[1]), .vme_berr_out(berr[1]),
        .grant_level(lvl[1]), .arb_busy(busy[1]), .timeout_event(tev[1]));

    always #10 clock = ~clock;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Inputs reach decisions two clocks after being sampled.
    logic [9:0] ms1, ms2;
    // Per arbiter: which BG is driven, how long it has waited for BBSY
    // (-1 = no grant outstanding), whether the bus is owned, and whether
    // we are in the post-release dead cycle.
    logic [3:0] e_bg   [2];
    logic       e_bclr [2];
    logic [1:0] e_lvl  [2];
    int         e_ptr  [2];
    int         e_wait [2];
    bit         e_own  [2];
    bit         e_dead [2];
    logic       e_tev  [2];
    int         e_cnt;
    logic       e_berr;

    task automatic model_reset();
        ms1 = '1; ms2 = '1;
        e_cnt = 0; e_berr = 1'b1;
        for (int m = 0; m < 2; m++) begin
            e_bg[m] = 4'hF; e_bclr[m] = 1'b1; e_lvl[m] = 2'd3; e_ptr[m] = 3;
            e_wait[m] = -1; e_own[m] = 0; e_dead[m] = 0; e_tev[m] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [3:0] sbr;
        logic       sbbsy, sas, sdtk, sbe;
        logic [1:0] sds;
        bit         fire, ato;
        int         pick, i;
        {sbr, sbbsy, sas, sds, sdtk, sbe} = ms2;

        // bus timer: count unanswered strobed clocks, BERR one clock after
        // the count reaches the limit, hold BERR until DS both released
        fire = 0;
        if (sds == 2'b11 || !sdtk || !sbe) begin
            e_cnt = 0;
            if (sds == 2'b11) e_berr = 1'b1;
        end else if (e_cnt == BT) begin
            if (e_berr) begin fire = 1; e_berr = 1'b0; end
        end else if (!sas) begin
            e_cnt++;
        end

        for (int m = 0; m < 2; m++) begin
            ato = 0;
            e_bclr[m] = 1'b1;
            if (e_dead[m]) begin
                e_dead[m] = 0;
            end else if (e_own[m]) begin
                if (sbbsy) begin
                    e_own[m] = 0; e_dead[m] = 1;
                end else if (m == 0) begin
                    for (int j = 0; j < 4; j++)
                        if (!sbr[j] && j > int'(e_lvl[m])) e_bclr[m] = 1'b0;
                end
            end else if (e_wait[m] >= 0) begin
                if (!sbbsy) begin
                    e_bg[m] = 4'hF; e_wait[m] = -1; e_own[m] = 1; e_ptr[m] = int'(e_lvl[m]);
                end else if (e_wait[m] == GT - 1) begin
                    e_bg[m] = 4'hF; e_wait[m] = -1; ato = 1;
                end else begin
                    e_wait[m]++;
                end
            end else if (!sbbsy) begin
                e_own[m] = 1;
            end else if (sbr != 4'hF) begin
                pick = -1;
                if (m == 0) begin
                    for (int j = 0; j < 4; j++) if (!sbr[j]) pick = j;
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        i = (e_ptr[m] - k + 4) % 4;
                        if (pick < 0 && !sbr[i]) pick = i;
                    end
                end
                e_lvl[m]  = 2'(pick);
                e_bg[m]   = ~(4'b0001 << pick);
                e_wait[m] = 0;
            end
            e_tev[m] = ato | fire;
        end
        ms2 = ms1;
        ms1 = {br, bbsy, astb, ds, dtack, berr_in};
    endtask

    task automatic cmp_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("bg%0d", m),   bg[m],   e_bg[m]);
            chk($sformatf("bclr%0d", m), bclr[m], e_bclr[m]);
            chk($sformatf("berr%0d", m), berr[m], e_berr);
            chk($sformatf("lvl%0d", m),  lvl[m],  e_lvl[m]);
            chk($sformatf("busy%0d", m), busy[m], (e_wait[m] >= 0) || e_own[m]);
            chk($sformatf("tev%0d", m),  tev[m],  e_tev[m]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        cmp_all();
    endtask

    task automatic wait_grant(input int m);
        int n = 0;
        while (bg[m] == 4'hF && n < 100) begin tick(); n++; end
        chk("grant_seen", bg[m] != 4'hF, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_bg"},   bg[m],   4'hF);
            chk({tag, "_bclr"}, bclr[m], 1);
            chk({tag, "_berr"}, berr[m], 1);
            chk({tag, "_lvl"},  lvl[m],  2'b11);
            chk({tag, "_busy"}, busy[m], 0);
            chk({tag, "_tev"},  tev[m],  0);
        end
    endtask

    int  n_tev, first;
    bit  seen;
    int  rr_exp [5];

    initial begin
        br = 4'hF; bbsy = 1; astb = 1; ds = 2'b11; dtack = 1; berr_in = 1;
        reset = 1;
        #5;
        model_reset();
        check_reset_vals("rst");
        repeat (2) @(posedge clock);
        #1 reset = 0;
        repeat (3) tick();

        // BR2 grant latency, ownership and release
        br = 4'b1011;
        repeat (2) tick();
        chk("bg_early", bg[0], 4'hF);
        tick();
        chk("bg_3rd_fp", bg[0], 4'b1011);
        chk("bg_3rd_rr", bg[1], 4'b1011);
        bbsy = 0; br = 4'hF;
        repeat (3) tick();
        chk("own_bg", bg[0], 4'hF);
        chk("own_busy", busy[0], 1);
        bbsy = 1;
        repeat (5) tick();
        chk("idle_busy", busy[0], 0);

        // BR0 owner, BR3 request -> BCLR on fixed priority only
        br = 4'b1110;
        wait_grant(0);
        bbsy = 0;
        repeat (4) tick();
        br = 4'b0110;
        repeat (3) tick();
        chk("bclr_fp", bclr[0], 0);
        chk("bclr_rr", bclr[1], 1);
        bbsy = 1; br = 4'b0111;
        repeat (4) tick();
        chk("dead_bg", bg[0], 4'hF);
        tick();
        chk("br3_fp", bg[0], 4'b0111);
        chk("br3_rr", bg[1], 4'b0111);
        bbsy = 0;
        repeat (4) tick();
        // hand the bus to BR0 so the round-robin pointer sits at 0
        br = 4'b1110; bbsy = 1;
        wait_grant(1);
        bbsy = 0;
        repeat (4) tick();
        bbsy = 1; br = 4'hF;
        repeat (6) tick();

        // round robin with all four requesting
        rr_exp = '{3, 2, 1, 0, 3};
        seen = 0;
        br = 4'b0000;
        for (int g = 0; g < 5; g++) begin
            wait_grant(1);
            chk($sformatf("rr_ord%0d", g), lvl[1], rr_exp[g]);
            repeat (2) begin tick(); seen |= !bclr[1]; end
            bbsy = 0;
            repeat (10) begin tick(); seen |= !bclr[1]; end
            bbsy = 1;
            if (g == 4) br = 4'hF;
        end
        chk("rr_no_bclr", seen, 0);
        repeat (10) tick();

        // grant never answered by BBSY
        br = 4'b1101;
        n_tev = 0;
        repeat (GT + 6) begin tick(); n_tev += int'(tev[1]); end
        chk("gto_pulses", n_tev, 1);
        chk("gto_regrant", bg[1], 4'b1101);
        br = 4'hF;
        repeat (GT + 5) tick();

        // bus timer fires
        astb = 0; ds = 2'b10;
        first = -1;
        for (int c = 1; c <= BT + 10; c++) begin
            tick();
            if (first < 0 && !berr[0]) first = c;
        end
        chk("bt_fire", first, BT + 3);
        ds = 2'b11; astb = 1;
        repeat (3) tick();
        chk("bt_release", berr[0], 1);

        // DTACK just before the limit wins
        astb = 0; ds = 2'b10;
        repeat (BT - 1) tick();
        dtack = 0;
        seen = 0;
        repeat (20) begin tick(); seen |= !berr[0]; end
        chk("bt_dtack", seen, 0);
        astb = 1; ds = 2'b11; dtack = 1;
        repeat (5) tick();

        // async reset while BUSY with BERR driven
        bbsy = 0; astb = 0; ds = 2'b01;
        repeat (BT + 5) tick();
        chk("pre_berr", berr[0], 0);
        chk("pre_busy", busy[0], 1);
        #3 reset = 1;
        #1;
        check_reset_vals("arst");
        model_reset();
        bbsy = 1; astb = 1; ds = 2'b11;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        repeat (2) tick();
        br = 4'b1101;
        repeat (3) tick();
        chk("post_rst_fp", bg[0], 4'b1101);
        chk("post_rst_rr", bg[1], 4'b1101);
        bbsy = 0; br = 4'hF;
        repeat (4) tick();
        bbsy = 1;
        repeat (4) tick();

        // randomized traffic
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) br      = 4'($urandom);
            if ($urandom_range(0, 5) == 0) bbsy    = 1'($urandom);
            if ($urandom_range(0, 9) == 0) astb    = 1'($urandom);
            if ($urandom_range(0, 9) == 0) ds      = 2'($urandom);
            if ($urandom_range(0, 9) == 0) dtack   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) berr_in = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
